// File: rtl/tri_assembler.sv
// Groups a serial vertex stream into homogeneous 3x4 triangles with valid/ready output.
// Define TRI_ASM_STRIP_EN for triangle-strip assembly (default: triangle list).
`timescale 1ns/1ps
module tri_assembler #(
    parameter logic [31:0] W_ONE = 32'h0001_0000,
    parameter int          CNT_W = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      vtx_valid_in,
    output logic                      vtx_ready_out,
    input  logic [31:0]               vtx_x_in,
    input  logic [31:0]               vtx_y_in,
    input  logic [31:0]               vtx_z_in,
    input  logic                      vtx_last_in,
    output logic [2:0][3:0][31:0]     homo_tri_out,
    output logic                      tri_valid_out,
    input  logic                      tri_ready_in,
    output logic                      tri_last_out,
    output logic                      partial_drop_out,
    output logic [CNT_W-1:0]          tri_count_out
);

    typedef enum logic {COLLECT, HOLD} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [1:0][3:0][31:0]   slot_q, slot_d;
    logic [2:0][3:0][31:0]   homo_tri_q, homo_tri_d;
    logic                    vtx_ready_q, vtx_ready_d;
    logic                    tri_valid_q, tri_valid_d;
    logic                    tri_last_q, tri_last_d;
    logic                    partial_drop_q, partial_drop_d;
    logic [CNT_W-1:0]        tri_count_q, tri_count_d;
`ifdef TRI_ASM_STRIP_EN
    logic                    parity_q, parity_d;
`endif

    logic [3:0][31:0] vtx_w;
    logic             vtx_fire;
    logic             tri_fire;

    assign vtx_w    = {W_ONE, vtx_z_in, vtx_y_in, vtx_x_in};
    assign vtx_fire = vtx_valid_in & vtx_ready_q;
    assign tri_fire = tri_valid_q & tri_ready_in;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        slot_d         = slot_q;
        homo_tri_d     = homo_tri_q;
        vtx_ready_d    = vtx_ready_q;
        tri_valid_d    = tri_valid_q;
        tri_last_d     = tri_last_q;
        partial_drop_d = 1'b0;
        tri_count_d    = tri_count_q;
`ifdef TRI_ASM_STRIP_EN
        parity_d       = parity_q;
`endif
        unique case (state_q)
            COLLECT: begin
                if (vtx_fire) begin
                    if (cnt_q == 2'd2) begin
                        homo_tri_d[2] = vtx_w;
`ifdef TRI_ASM_STRIP_EN
                        // Odd strip triangles swap the first two vertices to keep winding.
                        homo_tri_d[0] = parity_q ? slot_q[1] : slot_q[0];
                        homo_tri_d[1] = parity_q ? slot_q[0] : slot_q[1];
                        slot_d[0]     = slot_q[1];
                        slot_d[1]     = vtx_w;
`else
                        homo_tri_d[0] = slot_q[0];
                        homo_tri_d[1] = slot_q[1];
`endif
                        tri_last_d  = vtx_last_in;
                        tri_valid_d = 1'b1;
                        vtx_ready_d = 1'b0;
                        state_d     = HOLD;
                    end else if (vtx_last_in) begin
                        cnt_d          = 2'd0;
                        partial_drop_d = 1'b1;
                    end else begin
                        slot_d[cnt_q[0]] = vtx_w;
                        cnt_d            = cnt_q + 2'd1;
                    end
                end
            end
            HOLD: begin
                if (tri_fire) begin
                    tri_valid_d = 1'b0;
                    tri_last_d  = 1'b0;
                    vtx_ready_d = 1'b1;
                    tri_count_d = tri_count_q + CNT_W'(1);
                    state_d     = COLLECT;
`ifdef TRI_ASM_STRIP_EN
                    cnt_d    = tri_last_q ? 2'd0 : 2'd2;
                    parity_d = tri_last_q ? 1'b0 : ~parity_q;
`else
                    cnt_d    = 2'd0;
`endif
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= COLLECT;
            cnt_q          <= 2'd0;
            slot_q         <= '0;
            homo_tri_q     <= '0;
            vtx_ready_q    <= 1'b1;
            tri_valid_q    <= 1'b0;
            tri_last_q     <= 1'b0;
            partial_drop_q <= 1'b0;
            tri_count_q    <= '0;
`ifdef TRI_ASM_STRIP_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            homo_tri_q     <= homo_tri_d;
            vtx_ready_q    <= vtx_ready_d;
            tri_valid_q    <= tri_valid_d;
            tri_last_q     <= tri_last_d;
            partial_drop_q <= partial_drop_d;
            tri_count_q    <= tri_count_d;
`ifdef TRI_ASM_STRIP_EN
            parity_q       <= parity_d;
`endif
        end
    end

    assign vtx_ready_out    = vtx_ready_q;
    assign homo_tri_out     = homo_tri_q;
    assign tri_valid_out    = tri_valid_q;
    assign tri_last_out     = tri_last_q;
    assign partial_drop_out = partial_drop_q;
    assign tri_count_out    = tri_count_q;

endmodule

// File: tb/tb_tri_assembler.sv
// Directed bench for tri_assembler: list, backpressure, partial, reset, wrap, strip.
`timescale 1ns/1ps
module tb_tri_assembler;

    localparam logic [31:0] W1 = 32'h0001_0000;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  vtx_valid = 1'b0;
    logic                  vtx_ready;
    logic [31:0]           vx = '0, vy = '0, vz = '0;
    logic                  vlast = 1'b0;
    logic [2:0][3:0][31:0] homo;
    logic                  tvalid;
    logic                  tready = 1'b0;
    logic                  tlast;
    logic                  pdrop;
    logic [3:0]            tcount;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    logic [383:0] snap;

    always #5 clk = ~clk;

    tri_assembler #(.W_ONE(W1), .CNT_W(4)) dut (
        .clk_in(clk), .rst_in(rst),
        .vtx_valid_in(vtx_valid), .vtx_ready_out(vtx_ready),
        .vtx_x_in(vx), .vtx_y_in(vy), .vtx_z_in(vz),
        .vtx_last_in(vlast),
        .homo_tri_out(homo), .tri_valid_out(tvalid),
        .tri_ready_in(tready), .tri_last_out(tlast),
        .partial_drop_out(pdrop), .tri_count_out(tcount)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [383:0] mk_tri(
        input logic [31:0] a0, a1, a2, b0, b1, b2, c0, c1, c2);
        return {W1, c2, c1, c0, W1, b2, b1, b0, W1, a2, a1, a0};
    endfunction

    task automatic chk_tri(input string tag, input logic [383:0] e);
        logic [383:0] h;
        h = homo;
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s[%0d][%0d]", tag, i / 4, i % 4),
                h[i*32 +: 32], e[i*32 +: 32]);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_vtx(input logic [31:0] x, y, z, input logic last);
        int n;
        n = 0;
        vtx_valid = 1'b1;
        vx = x; vy = y; vz = z; vlast = last;
        while (!vtx_ready && n < 50) begin
            cyc();
            n++;
        end
        if (n == 50) chk("vtx_wait_timeout", 32'd0, 32'd1);
        cyc();
        vtx_valid = 1'b0;
        vlast = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(tvalid), 32'd0);
        chk({tag, "_ready"}, 32'(vtx_ready), 32'd1);
        chk({tag, "_last"}, 32'(tlast), 32'd0);
        chk({tag, "_drop"}, 32'(pdrop), 32'd0);
        chk({tag, "_count"}, 32'(tcount), 32'd0);
        chk({tag, "_homo"}, 32'(homo == '0), 32'd1);
    endtask

    initial begin
        cyc(); cyc();
        chk_reset_vals("rst_init");
        rst = 1'b0;
        cyc();
        chk_reset_vals("post_rst");

        // list triangle, last on third vertex
        tready = 1'b1;
        put_vtx(1, 2, 3, 1'b0);
        put_vtx(4, 5, 6, 1'b0);
        put_vtx(7, 8, 9, 1'b1);
        chk("list_valid", 32'(tvalid), 32'd1);
        chk("list_vready", 32'(vtx_ready), 32'd0);
        chk("list_last", 32'(tlast), 32'd1);
        chk_tri("list", mk_tri(1, 2, 3, 4, 5, 6, 7, 8, 9));
        cyc();
        exp_cnt++;
        chk("list_valid_drop", 32'(tvalid), 32'd0);
        chk("list_count", 32'(tcount), 32'(exp_cnt % 16));
        chk("list_vready2", 32'(vtx_ready), 32'd1);

        // backpressure
        tready = 1'b0;
        put_vtx(32'hFFFF_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0);
        put_vtx(32'h8000_0000, 32'd11, 32'd12, 1'b0);
        put_vtx(32'd13, 32'd14, 32'hDEAD_BEEF, 1'b1);
        snap = homo;
        chk_tri("bp", mk_tri(32'hFFFF_0000, 32'h0000_8000, 32'h7FFF_FFFF,
                             32'h8000_0000, 32'd11, 32'd12,
                             32'd13, 32'd14, 32'hDEAD_BEEF));
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(tvalid), 32'd1);
            chk("bp_stable", 32'(homo == snap), 32'd1);
            chk("bp_vready", 32'(vtx_ready), 32'd0);
            chk("bp_count", 32'(tcount), 32'(exp_cnt % 16));
            cyc();
        end
        tready = 1'b1;
        cyc();
        exp_cnt++;
        chk("bp_hs_valid", 32'(tvalid), 32'd0);
        chk("bp_hs_count", 32'(tcount), 32'(exp_cnt % 16));

`ifdef TRI_ASM_STRIP_EN
        // strip: A,B,C,D,E -> ABC, CBD, CDE
        put_vtx(10, 11, 12, 1'b0);
        put_vtx(20, 21, 22, 1'b0);
        put_vtx(30, 31, 32, 1'b0);
        chk("strip1_last", 32'(tlast), 32'd0);
        chk_tri("strip1", mk_tri(10, 11, 12, 20, 21, 22, 30, 31, 32));
        put_vtx(40, 41, 42, 1'b0);
        exp_cnt++;
        chk("strip2_last", 32'(tlast), 32'd0);
        chk_tri("strip2", mk_tri(30, 31, 32, 20, 21, 22, 40, 41, 42));
        put_vtx(50, 51, 52, 1'b1);
        exp_cnt++;
        chk("strip3_valid", 32'(tvalid), 32'd1);
        chk("strip3_last", 32'(tlast), 32'd1);
        chk_tri("strip3", mk_tri(30, 31, 32, 40, 41, 42, 50, 51, 52));
        cyc();
        exp_cnt++;
        chk("strip_count", 32'(tcount), 32'(exp_cnt % 16));
        chk("strip_vready", 32'(vtx_ready), 32'd1);
`else
        // partial mesh: 5 vertices, last on 5th
        put_vtx(1, 1, 1, 1'b0);
        put_vtx(2, 2, 2, 1'b0);
        put_vtx(3, 3, 3, 1'b0);
        chk("part_valid", 32'(tvalid), 32'd1);
        chk("part_last", 32'(tlast), 32'd0);
        put_vtx(4, 4, 4, 1'b0);
        exp_cnt++;
        chk("part_drop_early", 32'(pdrop), 32'd0);
        put_vtx(5, 5, 5, 1'b1);
        chk("part_drop", 32'(pdrop), 32'd1);
        chk("part_no_valid", 32'(tvalid), 32'd0);
        cyc();
        chk("part_drop_end", 32'(pdrop), 32'd0);
        chk("part_count", 32'(tcount), 32'(exp_cnt % 16));
        put_vtx(6, 6, 6, 1'b0);
        put_vtx(7, 7, 7, 1'b0);
        put_vtx(8, 8, 8, 1'b1);
        chk_tri("part_fresh", mk_tri(6, 6, 6, 7, 7, 7, 8, 8, 8));
        cyc();
        exp_cnt++;
        chk("part_count2", 32'(tcount), 32'(exp_cnt % 16));
`endif

        // reset while holding a triangle
        tready = 1'b0;
        put_vtx(9, 9, 9, 1'b0);
        put_vtx(8, 8, 8, 1'b0);
        put_vtx(7, 7, 7, 1'b1);
        chk("hold_valid", 32'(tvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_hold");
        cyc();
        rst = 1'b0;
        exp_cnt = 0;
        tready = 1'b1;
        cyc();
        chk_reset_vals("rst_after");

        // counter wrap with 4-bit counter
        for (int t = 0; t < 17; t++) begin
            put_vtx(32'(t), 1, 2, 1'b0);
            put_vtx(3, 32'(t), 4, 1'b0);
            put_vtx(5, 6, 32'(t), 1'b1);
            cyc();
            exp_cnt++;
            if (t == 15) chk("wrap_zero", 32'(tcount), 32'd0);
        end
        chk("wrap_one", 32'(tcount), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tri_assembler.md
# tri_assembler

Builds homogeneous triangles from a serial vertex stream and hands them to the projection stage. Accepts one 3-D vertex per handshake, appends the homogeneous coordinate w, groups vertices into triangles and presents each as a registered 3×4 array with a valid/ready handshake. It sits between the vertex source (mesh ROM reader) and the triangle projection stage.

## Interface

Parameters:
- W_ONE, 32'h0001_0000, value written to coordinate [3] (w) of every vertex; 1.0 in 16.16 fixed point.
- CNT_W, 16, width of the emitted-triangle counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- vtx_valid_in  input  1  vertex present on vtx_*_in
- vtx_ready_out  output  1  assembler accepts a vertex this cycle
- vtx_x_in, vtx_y_in, vtx_z_in  input  32 each  vertex coordinates, 16.16 signed, passed through unmodified
- vtx_last_in  input  1  qualifies the accepted vertex as the final vertex of the mesh
- homo_tri_out  output  [2:0][3:0] × 32  triangle; [v][0..3] = x, y, z, w
- tri_valid_out  output  1  homo_tri_out holds a complete triangle
- tri_ready_in  input  1  downstream takes the triangle
- tri_last_out  output  1  triangle is the last of the mesh; valid with tri_valid_out
- partial_drop_out  output  1  one-cycle pulse: mesh ended with an incomplete triangle
- tri_count_out  output  CNT_W  triangles handed off since reset; wraps at 2^CNT_W

## Operation

- States: COLLECT, HOLD.
- Reset: state COLLECT, vertex count 0, vtx_ready_out 1, tri_valid_out 0, tri_last_out 0, partial_drop_out 0, tri_count_out 0, homo_tri_out all zero.
- COLLECT: vtx_ready_out = 1. On vtx_valid_in & vtx_ready_out, store x,y,z,W_ONE in slot [count]; count increments.
  - Third vertex stored (count reaches 3): homo_tri_out loads all three slots, tri_last_out = vtx_last_in, state HOLD.
  - vtx_last_in accepted with count < 3 after the increment: all slots discarded, count 0, partial_drop_out pulses next cycle, state stays COLLECT.
- HOLD: vtx_ready_out = 0; homo_tri_out and tri_last_out stable. On tri_valid_out & tri_ready_in: tri_count_out increments, tri_valid_out drops next cycle, state COLLECT, count 0 (list mode).
- tri_valid_out never drops without a handshake; output stays stable while stalled.
- A vtx_valid_in that goes away without a handshake has no effect.

## Timing

- tri_valid_out asserts on the cycle after the third vertex handshake (1-cycle latency).
- Next vertex is accepted on the cycle after the output handshake at the earliest; minimum 4 cycles per triangle in list mode.
- tri_ready_in asserted before tri_valid_out completes the handshake on the first valid cycle.
- rst_in asserted mid-operation, including in HOLD, clears everything immediately to the reset values; the held triangle is lost and not counted.
- Coordinates are not range-checked or converted; there is no arithmetic beyond counters.

## Configuration

- TRI_ASM_STRIP_EN defined: triangle-strip mode. After an output handshake where tri_last_out = 0, slots 1 and 2 shift to 0 and 1, count becomes 2, and each further vertex completes a triangle. Every odd strip triangle (2nd, 4th, …) outputs slots in order 1,0,2 to preserve winding; the parity counter clears on reset and after a last triangle. A last triangle returns count to 0. Throughput is 2 cycles per triangle after the first.
- Undefined: triangle list only, as described in Operation; no parity logic.

## Test plan

- List mode: vertices (1,2,3), (4,5,6), (7,8,9) back to back, tri_ready_in = 1 → one triangle with [0]=(1,2,3,0x10000), [1]=(4,5,6,0x10000), [2]=(7,8,9,0x10000), valid for 1 cycle, tri_count_out = 1.
- Backpressure: tri_ready_in = 0 for 10 cycles → tri_valid_out and homo_tri_out stable and vtx_ready_out = 0 throughout; the handshake happens on the cycle tri_ready_in rises.
- Partial mesh: 5 vertices with vtx_last_in on the 5th → one triangle with tri_last_out = 0, then a partial_drop_out pulse, tri_count_out = 1.
- Reset in HOLD: assert rst_in while tri_valid_out = 1 → all outputs at reset values the same cycle, tri_count_out = 0.
- Strip mode (TRI_ASM_STRIP_EN), vertices A,B,C,D,E with last on E → triangles (A,B,C), (C,B,D), (C,D,E); the third has tri_last_out = 1; tri_count_out = 3.
- Counter wrap at CNT_W = 4: 17 triangles → tri_count_out = 1.
